hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller. Owns per-stage valid bits and drives
//            stall/flush for load-use interlock, redirect and memory
//            back-pressure. Define HAZARD_PERF_EN to add perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NSTAGES    = 5,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int BR_STAGE   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wen,
    input  logic                  ex_is_load,
    input  logic                  redirect,
    input  logic                  mem_busy,
    output logic                  pc_en,
    output logic [NSTAGES-1:0]    stall,
    output logic [NSTAGES-1:0]    flush,
    output logic [NSTAGES-1:0]    valid
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam logic [1:0]         C_LOAD_LAT = 2'(LOAD_LAT);
    localparam logic [NSTAGES-1:0] C_ONE      = 1;
    // Bubbles into stages 1..BR_STAGE; the resolving branch itself proceeds
    localparam logic [NSTAGES-1:0] C_BR_FLUSH = (C_ONE << (BR_STAGE + 1)) - (C_ONE << 1);

    logic [NSTAGES-1:0] r_valid;
    logic [NSTAGES-1:0] w_valid_nxt;
    logic [1:0]         r_lu_cnt;
    logic [1:0]         w_lu_cnt_nxt;
    logic               w_lu_detect;
    logic               w_lu_active;

    assign w_lu_detect = r_valid[2] & ex_is_load & ex_wen & (ex_rd != '0) &
                         ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    // A fresh detect is only honoured when no interlock is already counting
    assign w_lu_active = (r_lu_cnt != 2'd0) | w_lu_detect;

    always_comb begin
        stall        = '0;
        flush        = '0;
        pc_en        = 1'b1;
        w_lu_cnt_nxt = r_lu_cnt;
        if (reset) begin
            flush        = '1;
            pc_en        = 1'b0;
            w_lu_cnt_nxt = 2'd0;
        end else if (mem_busy) begin
            stall[NSTAGES-2:0]  = '1;
            flush[NSTAGES-1]    = 1'b1;
            pc_en               = 1'b0;
        end else if (redirect) begin
            flush        = C_BR_FLUSH;
            w_lu_cnt_nxt = 2'd0;
        end else if (w_lu_active) begin
            stall[1:0]   = 2'b11;
            flush[2]     = 1'b1;
            pc_en        = 1'b0;
            w_lu_cnt_nxt = (r_lu_cnt != 2'd0) ? (r_lu_cnt - 2'd1) : C_LOAD_LAT;
        end
    end

    assign w_valid_nxt[0] = flush[0] ? 1'b0 : (stall[0] ? r_valid[0] : 1'b1);

    generate
        for (genvar gi = 1; gi < NSTAGES; gi++) begin : g_valid_nxt
            assign w_valid_nxt[gi] = flush[gi] ? 1'b0 : (stall[gi] ? r_valid[gi] : r_valid[gi-1]);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid  <= '0;
            r_lu_cnt <= 2'd0;
        end else begin
            r_valid  <= w_valid_nxt;
            r_lu_cnt <= w_lu_cnt_nxt;
        end
    end

    assign valid = r_valid;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (!pc_en) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (redirect && !mem_busy) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
`default_nettype wire
